// File: rtl/sine_table_loader_pkg.sv
// Shared defaults, table depth and FSM encoding for the sine table loader.
// Imported by the loader top and its table RAM.
package sine_table_loader_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 64;
   localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sine_table_loader_table_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port with enable.
// Read-during-write to the same address returns the previously stored word.
module table_ram
   import sine_table_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Array has no reset so it can map onto block RAM.
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sine_table_loader.sv
// Loads a DEPTH-word table through a valid/ready write stream and serves
// registered reads from it in every state.
module sine_table_loader
   import sine_table_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              loaded,
   output state_e            dbg_state_o
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   // Handshake: a word transfers on a posedge where wr_valid && wr_ready.
   // wr_ready is a registered decode of the LOAD state, never a function of wr_valid.
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              wr_ready_q, busy_q, loaded_q;
   logic              wr_fire;

   assign wr_fire = wr_valid & wr_ready_q;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d  = ST_LOAD;
               wr_ptr_d = '0;
            end
         end
         ST_LOAD: begin
            // start is deliberately not looked at here: a load cannot be restarted.
            if (wr_fire) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_ptr_q == LAST_PTR) begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         wr_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         loaded_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_ready_q <= (state_d == ST_LOAD);
         busy_q     <= (state_d == ST_LOAD);
         loaded_q   <= (state_d == ST_DONE);
      end
   end

   table_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_table_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_fire),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .re_i    (rd_en),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   assign wr_ready    = wr_ready_q;
   assign busy        = busy_q;
   assign loaded      = loaded_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sine_table_loader.sv
// Directed-plus-random bench for sine_table_loader against a table-level
// reference model (word count, loading/done flags, expected memory image).
module tb_sine_table_loader;
   import sine_table_loader_pkg::*;

   localparam int AW    = 6;
   localparam int DW    = 64;
   localparam int DEPTH = 64;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          start    = 1'b0;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data  = '0;
   logic          rd_en    = 1'b0;
   logic [AW-1:0] rd_addr  = '0;
   logic          wr_ready, busy, loaded;
   logic [DW-1:0] rd_data;
   state_e        dbg_state;

   sine_table_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_ready    (wr_ready),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy),
      .loaded      (loaded),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int busy_cnt = 0;
   int acc_cnt  = 0;

   // Reference model of the table and the load progress.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_vld [DEPTH];
   bit            m_loading  = 1'b0;
   bit            m_done     = 1'b0;
   int            m_count    = 0;
   logic [DW-1:0] m_rd       = '0;
   bit            m_rd_known = 1'b1;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string pfx);
      check({pfx, "_busy"},     {63'b0, busy},     {63'b0, m_loading});
      check({pfx, "_loaded"},   {63'b0, loaded},   {63'b0, m_done});
      check({pfx, "_wr_ready"}, {63'b0, wr_ready}, {63'b0, m_loading});
      if (m_rd_known) check({pfx, "_rd_data"}, rd_data, m_rd);
   endtask

   // One clock: model computes the edge's effect from current inputs, then compare.
   task automatic cycle();
      logic [DW-1:0] nrd;
      bit            nknown;
      nrd    = m_rd;
      nknown = m_rd_known;
      if (rd_en) begin
         nrd    = m_mem[rd_addr];
         nknown = m_vld[rd_addr];
      end
      if (wr_valid && wr_ready) acc_cnt++;
      if (m_loading) begin
         if (wr_valid) begin
            m_mem[m_count] = wr_data;
            m_vld[m_count] = 1'b1;
            m_count++;
            if (m_count == DEPTH) begin
               m_loading = 1'b0;
               m_done    = 1'b1;
            end
         end
      end else if (start) begin
         m_loading = 1'b1;
         m_done    = 1'b0;
         m_count   = 0;
      end
      @(posedge clk);
      #1;
      m_rd       = nrd;
      m_rd_known = nknown;
      if (busy) busy_cnt++;
      check_outputs("cyc");
   endtask

   // Asynchronous reset asserted between edges and checked before the next edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      m_loading  = 1'b0;
      m_done     = 1'b0;
      m_rd       = '0;
      m_rd_known = 1'b1;
      check_outputs("rst");
      #2;
      rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      wr_valid = 1'b0;
      start    = 1'b1;
      cycle();
      start    = 1'b0;
   endtask

   // kind 0: data = index, 1: random data. gapped adds random valid gaps, starts and reads.
   task automatic run_load(input int kind, input bit gapped);
      int cyc = 0;
      while (m_loading && cyc < 2000) begin
         wr_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
         wr_data  = (kind == 0) ? DW'(m_count) : {$urandom, $urandom};
         if (gapped) begin
            start   = ($urandom_range(0, 7) == 0);
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
         end
         cycle();
         cyc++;
      end
      wr_valid = 1'b0;
      start    = 1'b0;
      rd_en    = 1'b0;
      check("load_complete", {63'b0, loaded}, 64'd1);
   endtask

   task automatic sweep();
      rd_en = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = AW'(a);
         cycle();
      end
      rd_en = 1'b0;
      cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      #1;
      check_outputs("rst0");
      #2;
      rst_n = 1'b1;

      // Idle with wr_valid asserted and no start.
      for (int i = 0; i < 10; i++) begin
         wr_valid = 1'b1;
         wr_data  = {$urandom, $urandom};
         cycle();
      end
      check("idle_rd_data", rd_data, 64'd0);
      wr_valid = 1'b0;

      // Full back-to-back load of 0..63, then readback sweep.
      busy_cnt = 0;
      pulse_start();
      run_load(0, 1'b0);
      check("full_busy_cycles", 64'(busy_cnt), 64'd64);
      sweep();

      // Reload with ~addr while probing address 5 around its overwrite.
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
         wr_valid = 1'b1;
         wr_data  = ~DW'(i);
         rd_en    = (i == 2) || (i == 5);
         rd_addr  = AW'(5);
         cycle();
         if (i == 2) check("reload_pre5", rd_data, 64'd5);
         if (i == 5) check("reload_same_edge5", rd_data, 64'd5);
      end
      wr_valid = 1'b0;
      rd_en    = 1'b1;
      rd_addr  = AW'(5);
      cycle();
      rd_en    = 1'b0;
      check("reload_post5", rd_data, ~64'd5);

      // Gapped load with mid-load start pulses and random reads.
      acc_cnt = 0;
      pulse_start();
      run_load(1, 1'b1);
      check("gapped_accepted", 64'(acc_cnt), 64'd64);
      sweep();

      // Reset after 20 words, then a fresh complete load.
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1'b1;
         wr_data  = {$urandom, $urandom};
         cycle();
      end
      wr_valid = 1'b0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1;
         cycle();
      end
      wr_valid = 1'b0;
      pulse_start();
      run_load(1, 1'b0);
      sweep();

      // Read hold: rd_data must not move while rd_en is low.
      rd_en   = 1'b1;
      rd_addr = AW'(9);
      cycle();
      rd_en   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rd_addr = AW'($urandom_range(0, DEPTH - 1));
         cycle();
         check("rd_hold", rd_data, m_mem[9]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sine_table_loader.md
SINE_TABLE_LOADER -- requirements
Module: sine_table_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, table address width (DEPTH = 2**ADDR_W = 64 words).
REQ-002 SHALL have parameter DATA_W, default 64, table word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a table load.
REQ-006 SHALL have port wr_valid  input  1  write word present on wr_data.
REQ-007 SHALL have port wr_data  input  DATA_W  word to store at the current write pointer.
REQ-008 SHALL have port wr_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have port rd_en  input  1  read enable, same semantics as the existing ROM read port.
REQ-010 SHALL have port rd_addr  input  ADDR_W  read address.
REQ-011 SHALL have port rd_data  output  DATA_W  registered read data.
REQ-012 SHALL have port busy  output  1  high while in LOAD.
REQ-013 SHALL have port loaded  output  1  high when all DEPTH words have been written since the last start.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, DONE; busy = (state==LOAD), loaded = (state==DONE).
REQ-015 IDLE: start=1 -> LOAD, wr_ptr <= 0; otherwise stay.
REQ-016 LOAD: wr_ready SHALL be 1; on wr_valid & wr_ready write mem[wr_ptr] <= wr_data, wr_ptr <= wr_ptr+1.
REQ-017 LOAD: the transfer with wr_ptr == DEPTH-1 SHALL move to DONE on the same edge; wr_ptr wraps to 0.
REQ-018 LOAD: start SHALL be ignored (no pointer restart).
REQ-019 DONE: start=1 -> LOAD, wr_ptr <= 0, loaded drops next cycle; table contents retained until overwritten.
REQ-020 wr_ready SHALL be 0 in IDLE and DONE; wr_valid there SHALL be ignored without side effect.
REQ-021 wr_ready SHALL be a registered state decode only (no combinational path from wr_valid).
REQ-022 Read: when rd_en=1 at posedge, rd_data <= mem[rd_addr] (1-cycle latency); rd_en=0 holds rd_data.
REQ-023 Reads SHALL be legal in every state; same-address read/write on one edge returns the OLD word.
REQ-024 Unwritten locations SHALL read as undefined; the bench SHALL not check them.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, wr_ptr 0, rd_data 0, wr_ready 0, busy 0, loaded 0.
REQ-026 Reset during LOAD SHALL abort the load; after release the block waits in IDLE for start.
REQ-027 Memory array SHALL NOT be reset (infers block RAM).

Structure
REQ-028 Shared package SHALL hold ADDR_W/DATA_W defaults, DEPTH and the FSM state encoding.
REQ-029 Storage SHALL be a sub-module table_ram: simple dual-port synchronous RAM, one write port, one registered read port with enable.
REQ-030 FSM, write pointer and handshake SHALL live in sine_table_loader; no other sub-modules.

Verification
REQ-031 Reset then idle: wr_valid=1 for 10 cycles without start -> wr_ready stays 0, loaded 0, rd_data 0.
REQ-032 Full load: start, then 64 back-to-back words 64'h0..64'h3F -> busy 64 cycles, loaded=1 after word 63; sweep rd_addr 0..63 with rd_en=1 -> rd_data equals addr one cycle later.
REQ-033 Gapped load: wr_valid toggled 1/0 pseudo-randomly -> exactly 64 accepted words, order preserved, start pulses mid-load ignored.
REQ-034 Reload: in DONE, start then write ~addr -> loaded low during LOAD; read of addr 5 before overwrite returns 5, after returns ~5; same-edge read/write of addr 5 returns 5.
REQ-035 Reset mid-load after 20 words -> busy/loaded 0 immediately; new start plus 64 words -> loaded=1 and all 64 locations correct.
REQ-036 Read hold: rd_en=0 while rd_addr changes -> rd_data unchanged.
